// File: rtl/display_printer.sv
// display_printer: buffers signed numbers and turns them into cursor-placed
// display commands (SCROLL / POS CLEAR / NUMBER) over a cmd/data/ready port.
module display_printer #(
   parameter int unsigned COLS       = 20,
   parameter int unsigned ROWS       = 45,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   input  logic        in_newline,
   output logic        in_ready,
   output logic [3:0]  cmd,
   output logic [47:0] data,
   input  logic        disp_ready
);

   localparam int unsigned NUM_W  = 32;
   localparam int unsigned POS_W  = 8;
   localparam int unsigned CMD_W  = 4;
   localparam int unsigned DATA_W = 2 * POS_W + NUM_W;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PTR_AW = PTR_W + 1;

   localparam logic [CMD_W-1:0] CMD_NOP    = CMD_W'(0);
   localparam logic [CMD_W-1:0] CMD_SCROLL = CMD_W'(1);
   localparam logic [CMD_W-1:0] CMD_CLEAR  = CMD_W'(2);
   localparam logic [CMD_W-1:0] CMD_NUMBER = CMD_W'(3);

   localparam logic [POS_W-1:0] COL_LAST = POS_W'(COLS - 1);
   localparam logic [POS_W-1:0] ROW_LAST = POS_W'(ROWS - 1);

   typedef struct packed {
      logic             newline;
      logic [NUM_W-1:0] num;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BREAK,
      S_CLEAR,
      S_NUMBER
   } state_t;

   // FIFO
   entry_t            r_mem [FIFO_DEPTH];
   logic [PTR_AW-1:0] r_wr_ptr;
   logic [PTR_AW-1:0] r_rd_ptr;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   entry_t            w_head;

   // Sequencer
   state_t             r_state;
   state_t             r_resume;
   logic [POS_W-1:0]   r_col;
   logic [POS_W-1:0]   r_row;
   logic [NUM_W-1:0]   r_num;
   logic               r_rdy_q;
   logic [CMD_W-1:0]   r_cmd;
   logic [DATA_W-1:0]  r_data;

   state_t             w_state_nxt;
   state_t             w_resume_nxt;
   logic [POS_W-1:0]   w_col_nxt;
   logic [POS_W-1:0]   w_row_nxt;
   logic [NUM_W-1:0]   w_num_nxt;
   logic [CMD_W-1:0]   w_cmd_nxt;
   logic [DATA_W-1:0]  w_data_nxt;
   logic               w_can_issue;

   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign in_ready = !rst && !w_full;
   assign w_push   = in_valid && in_ready;
   assign w_head   = r_mem[r_rd_ptr[PTR_W-1:0]];

   // A new command needs a freshly sampled ready and an idle command bus
   assign w_can_issue = r_rdy_q && (r_cmd == CMD_NOP);

   assign cmd  = r_cmd;
   assign data = r_data;

   // FIFO storage; contents need no reset because the pointers gate every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= {in_newline, in_data};
      end
   end

   // FIFO pointers with an extra wrap bit to tell full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_AW'(1);
      end
   end

   // Sequencer next-state, cursor update and command generation
   always_comb begin
      w_state_nxt  = r_state;
      w_resume_nxt = r_resume;
      w_col_nxt    = r_col;
      w_row_nxt    = r_row;
      w_num_nxt    = r_num;
      w_cmd_nxt    = CMD_NOP;
      w_data_nxt   = r_data;
      w_pop        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_num_nxt = w_head.num;
               if (w_head.newline && (r_col != '0)) begin
                  w_state_nxt  = S_BREAK;
                  w_resume_nxt = S_CLEAR;
               end else begin
                  w_state_nxt = S_CLEAR;
               end
            end
         end

         S_BREAK: begin
            if (r_row == ROW_LAST) begin
               if (w_can_issue) begin
                  w_cmd_nxt   = CMD_SCROLL;
                  w_data_nxt  = '0;
                  w_col_nxt   = '0;
                  w_state_nxt = r_resume;
               end
            end else begin
               w_row_nxt   = r_row + POS_W'(1);
               w_col_nxt   = '0;
               w_state_nxt = r_resume;
            end
         end

         S_CLEAR: begin
            if (w_can_issue) begin
               w_cmd_nxt   = CMD_CLEAR;
               w_data_nxt  = {r_col, r_row, NUM_W'(0)};
               w_state_nxt = S_NUMBER;
            end
         end

         S_NUMBER: begin
            if (w_can_issue) begin
               w_cmd_nxt  = CMD_NUMBER;
               w_data_nxt = {r_col, r_row, r_num};
               w_col_nxt  = r_col + POS_W'(1);
               if (r_col == COL_LAST) begin
                  w_state_nxt  = S_BREAK;
                  w_resume_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Sequencer registers, registered command outputs and ready sampler
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_resume <= S_IDLE;
         r_col    <= '0;
         r_row    <= '0;
         r_num    <= '0;
         r_rdy_q  <= 1'b0;
         r_cmd    <= CMD_NOP;
         r_data   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_resume <= w_resume_nxt;
         r_col    <= w_col_nxt;
         r_row    <= w_row_nxt;
         r_num    <= w_num_nxt;
         r_rdy_q  <= disp_ready;
         r_cmd    <= w_cmd_nxt;
         r_data   <= w_data_nxt;
      end
   end

endmodule

// File: tb/tb_display_printer.sv
// tb_display_printer: directed and random entries against a cursor-level
// reference model, with a simple busy/ready display model on the command side.
module tb_display_printer;

   localparam int unsigned COLS  = 20;
   localparam int unsigned ROWS  = 45;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_newline;
   logic        in_ready;
   logic [3:0]  cmd;
   logic [47:0] data;
   logic        disp_ready;

   display_printer #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_newline (in_newline),
      .in_ready   (in_ready),
      .cmd        (cmd),
      .data       (data),
      .disp_ready (disp_ready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model: cursor placement rules ----------------
   logic [51:0] exp_q[$];
   logic [51:0] log_q[$];
   int          m_col = 0;
   int          m_row = 0;
   bit          rst_pulse = 1'b0;

   function automatic logic [51:0] mk(input int c, input int x, input int y, input logic [31:0] n);
      return {4'(c), 8'(x), 8'(y), n};
   endfunction

   task automatic m_line_break();
      if (m_row == ROWS - 1) exp_q.push_back(mk(1, 0, 0, 32'd0));
      else m_row++;
      m_col = 0;
   endtask

   task automatic m_entry(input logic [31:0] v, input logic nl);
      if (nl && m_col != 0) m_line_break();
      exp_q.push_back(mk(2, m_col, m_row, 32'd0));
      exp_q.push_back(mk(3, m_col, m_row, v));
      m_col++;
      if (m_col == COLS) m_line_break();
   endtask

   // Observe accepted entries and resets at the clock edge
   initial forever begin
      @(posedge clk);
      rst_pulse = rst;
      if (rst) begin
         exp_q.delete();
         m_col = 0;
         m_row = 0;
      end else if (in_valid && in_ready) begin
         m_entry(in_data, in_newline);
      end
   end

   // ---------------- display model ----------------
   int busy_cnt = 0;
   int dmax     = 3;
   bit hold     = 1'b0;

   assign disp_ready = (busy_cnt == 0) && (cmd == 4'd0) && !hold;

   initial forever begin
      @(posedge clk);
      if (cmd != 4'd0 && busy_cnt == 0) busy_cnt <= int'($urandom_range(dmax, 1));
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 1'b0;

   initial begin : cmp
      logic [3:0]  prev_cmd;
      logic [47:0] last_data;
      logic [51:0] e;
      int          low_run;
      prev_cmd  = 4'd0;
      last_data = 48'd0;
      low_run   = 0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (rst_pulse) last_data = 48'd0;
            if (cmd != 4'd0) begin
               check("cmd_one_cycle", 64'(prev_cmd), 64'd0);
               check("issue_after_ready", 64'(low_run < 2), 64'd1);
               check("display_idle_at_issue", 64'(busy_cnt), 64'd0);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_cmd: got cmd %0d data 0x%0h, expected none", cmd, data);
               end else begin
                  e = exp_q.pop_front();
                  check("cmd", 64'(cmd), 64'(e[51:48]));
                  check("data", 64'(data), 64'(e[47:0]));
               end
               log_q.push_back({cmd, data});
               last_data = data;
            end else begin
               check("data_hold", 64'(data), 64'(last_data));
            end
            prev_cmd = cmd;
            low_run  = disp_ready ? 0 : low_run + 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [31:0] v, input logic nl);
      int n;
      n = 0;
      @(negedge clk);
      in_valid   = 1'b1;
      in_data    = v;
      in_newline = nl;
      while (!in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL push_timeout: in_ready stuck at 0, expected 1");
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      repeat (3) @(negedge clk);
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      repeat (8) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      hold     = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      log_q.delete();
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int n;
      int cyc;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = 32'd0;
      in_newline = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_cmd", 64'(cmd), 64'd0);
      check("rst_data", 64'(data), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1 check("in_ready_after_rst", 64'(in_ready), 64'd1);

      // single entry, then cursor continues at x=1
      push(32'd42, 1'b0);
      drain();
      check("single_size", 64'(log_q.size()), 64'd2);
      check("single_clear", 64'(log_q[0]), 64'(mk(2, 0, 0, 32'd0)));
      check("single_number", 64'(log_q[1]), 64'(mk(3, 0, 0, 32'd42)));
      push(32'd43, 1'b0);
      drain();
      check("second_number", 64'(log_q[3]), 64'(mk(3, 1, 0, 32'd43)));

      // full line: eager wrap without scroll
      do_reset();
      for (int i = 1; i <= 21; i++) push(32'(i), 1'b0);
      drain();
      check("line_size", 64'(log_q.size()), 64'd42);
      check("line_last_slot", 64'(log_q[39]), 64'(mk(3, 19, 0, 32'd20)));
      check("line_wrap_clear", 64'(log_q[40]), 64'(mk(2, 0, 1, 32'd0)));
      check("line_wrap_number", 64'(log_q[41]), 64'(mk(3, 0, 1, 32'd21)));
      n = 0;
      foreach (log_q[i]) if (log_q[i][51:48] == 4'd1) n++;
      check("line_no_scroll", 64'(n), 64'd0);

      // newlines: ignored at col 0, honoured otherwise
      do_reset();
      push(32'd3, 1'b1);
      push(32'd5, 1'b0);
      push(32'd7, 1'b1);
      drain();
      check("nl_size", 64'(log_q.size()), 64'd6);
      check("nl_at_col0", 64'(log_q[1]), 64'(mk(3, 0, 0, 32'd3)));
      check("nl_plain", 64'(log_q[3]), 64'(mk(3, 1, 0, 32'd5)));
      check("nl_break", 64'(log_q[5]), 64'(mk(3, 0, 1, 32'd7)));

      // bottom-right corner: write then scroll
      do_reset();
      dmax = 1;
      for (int k = 0; k <= 44; k++) push(32'(k), k != 0);
      for (int k = 0; k < 18; k++) push(32'(100 + k), 1'b0);
      push(32'd1000, 1'b0);
      push(32'd2000, 1'b0);
      drain();
      check("corner_size", 64'(log_q.size()), 64'd131);
      check("corner_number", 64'(log_q[127]), 64'(mk(3, 19, 44, 32'd1000)));
      check("corner_scroll", 64'(log_q[128]), 64'(mk(1, 0, 0, 32'd0)));
      check("corner_next_clear", 64'(log_q[129]), 64'(mk(2, 0, 44, 32'd0)));
      check("corner_next_number", 64'(log_q[130]), 64'(mk(3, 0, 44, 32'd2000)));
      dmax = 3;

      // backpressure while the display is held not-ready
      do_reset();
      hold = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) push(32'(101 + i), 1'b0);
      @(negedge clk);
      in_valid   = 1'b1;
      in_data    = 32'd106;
      in_newline = 1'b0;
      repeat (8) @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("held_no_cmd", 64'(log_q.size()), 64'd0);
      hold = 1'b0;
      n = 0;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("sixth_accepted", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();
      check("bp_size", 64'(log_q.size()), 64'd12);
      for (int i = 0; i < 6; i++)
         check("bp_order", 64'(log_q[2 * i + 1]), 64'(mk(3, i, 0, 32'(101 + i))));

      // reset during a NUMBER issue
      do_reset();
      push(32'd55, 1'b0);
      push(32'd56, 1'b0);
      push(32'd57, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cmd != 4'd3 && n < 400);
      check("saw_number_before_rst", 64'(cmd), 64'd3);
      rst = 1'b1;
      #1 check("rst_mid_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("rst_mid_cmd", 64'(cmd), 64'd0);
      check("rst_mid_data", 64'(data), 64'd0);
      rst = 1'b0;
      log_q.delete();
      hold = 1'b1;
      push(32'd77, 1'b1);
      repeat (8) @(negedge clk);
      check("rst_held_no_cmd", 64'(log_q.size()), 64'd0);
      hold = 1'b0;
      drain();
      check("rst_after_size", 64'(log_q.size()), 64'd2);
      check("rst_after_clear", 64'(log_q[0]), 64'(mk(2, 0, 0, 32'd0)));
      check("rst_after_number", 64'(log_q[1]), 64'(mk(3, 0, 0, 32'd77)));

      // random traffic with random display stalls
      do_reset();
      dmax = 4;
      n   = 0;
      cyc = 0;
      while (n < 400 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         hold = ($urandom_range(4, 0) == 0);
         if ($urandom_range(2, 0) != 0) begin
            in_valid   = 1'b1;
            in_data    = $urandom;
            in_newline = ($urandom_range(3, 0) == 0);
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && in_ready) n++;
      end
      check("random_entries", 64'(n), 64'd400);
      @(negedge clk);
      in_valid = 1'b0;
      hold     = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
